// File: rtl/slv_i2c_pkg.sv
// Shared types and constants for the I2C slave register-bank controller.
package slv_i2c_pkg;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_PTR   = 5'b00010,
    ST_WDATA = 5'b00100,
    ST_RDATA = 5'b01000,
    ST_SKIP  = 5'b10000
  } state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [6:0] DEF_ADDR_SLV = 7'h3C;

endpackage

// File: rtl/slv_i2c_regfile.sv
// Register array with one prioritised write port (I2C over user) and two read ports.
module slv_i2c_regfile #(
  parameter int DATA_SZ = 8,
  parameter int REG_NUM = 16,
  parameter int PTR_W   = $clog2(REG_NUM)
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               I_I2C_WE,
  input  logic [PTR_W-1:0]   I_I2C_ADDR,
  input  logic [DATA_SZ-1:0] I_I2C_WDATA,
  input  logic               I_USR_WE,
  input  logic [PTR_W-1:0]   I_USR_ADDR,
  input  logic [DATA_SZ-1:0] I_USR_WDATA,
  input  logic [PTR_W-1:0]   I_PTR,
  output logic [DATA_SZ-1:0] O_PTR_RDATA,
  output logic [DATA_SZ-1:0] O_USR_RDATA,
  output logic               O_USR_COLL
);

  logic [DATA_SZ-1:0] regs_q [REG_NUM];
  logic               coll_q;
  logic               we_d;
  logic [PTR_W-1:0]   waddr_d;
  logic [DATA_SZ-1:0] wdata_d;

  // The I2C side cannot be stalled, so it always wins the single write port.
  always_comb begin
    we_d    = I_I2C_WE | I_USR_WE;
    waddr_d = I_I2C_WE ? I_I2C_ADDR  : I_USR_ADDR;
    wdata_d = I_I2C_WE ? I_I2C_WDATA : I_USR_WDATA;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
      coll_q <= 1'b0;
    end else begin
      if (we_d) regs_q[waddr_d] <= wdata_d;
      coll_q <= I_I2C_WE & I_USR_WE;
    end
  end

  assign O_PTR_RDATA = regs_q[I_PTR];
  assign O_USR_RDATA = regs_q[I_USR_ADDR];
  assign O_USR_COLL  = coll_q;

endmodule

// File: rtl/slv_i2c_reg_ctrl.sv
// Decodes latched I2C command/data bytes, drives ACK/NACK and the auto-incrementing register pointer.
module slv_i2c_reg_ctrl
  import slv_i2c_pkg::*;
#(
  parameter int                 DATA_SZ  = 8,
  parameter logic [DATA_SZ-2:0] ADDR_SLV = DEF_ADDR_SLV,
  parameter int                 REG_NUM  = 16,
  localparam int                PTR_W    = $clog2(REG_NUM)
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic [DATA_SZ-2:0] I_ADDR_SLV,
  input  logic               I_RW,
  input  logic [DATA_SZ-1:0] I_DATA_RD,
  input  logic               I_DATA_VL,
  input  logic               I_BUSY,
  input  logic               I_BYTE_TX,
  input  logic               I_ACK_MSTR,
  output logic               O_ACK,
  output logic [DATA_SZ-1:0] O_DATA_WR,
  output logic [PTR_W-1:0]   O_REG_PTR,
  output logic               O_WR_STB,
  output logic [PTR_W-1:0]   O_WR_ADDR,
  input  logic [PTR_W-1:0]   I_USR_ADDR,
  output logic [DATA_SZ-1:0] O_USR_RDATA,
  input  logic               I_USR_WE,
  input  logic [DATA_SZ-1:0] I_USR_WDATA,
  output logic               O_USR_COLL,
  output logic [4:0]         O_STATE
);

  localparam logic [DATA_SZ:0] REG_NUM_V = (DATA_SZ+1)'(REG_NUM);

  state_e             state_q;
  logic               vl_q;
  logic               busy_q;
  logic [PTR_W-1:0]   ptr_q;
  logic               ack_q;
  logic [DATA_SZ-1:0] data_q;
  logic               wr_stb_q;
  logic [PTR_W-1:0]   wr_addr_q;

  logic               ev;
  logic               busy_fall;
  logic               ptr_ok;
  logic               i2c_we_d;
  logic [DATA_SZ-1:0] ptr_rdata;

  assign ev        = I_DATA_VL & ~vl_q;
  assign busy_fall = busy_q & ~I_BUSY;
  assign ptr_ok    = {1'b0, I_DATA_RD} < REG_NUM_V;
  // End of transaction suppresses a data byte seen in the same cycle.
  assign i2c_we_d  = (state_q == ST_WDATA) && ev && !busy_fall;

  slv_i2c_regfile #(
    .DATA_SZ(DATA_SZ),
    .REG_NUM(REG_NUM),
    .PTR_W  (PTR_W)
  ) u_regfile (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .I_I2C_WE   (i2c_we_d),
    .I_I2C_ADDR (ptr_q),
    .I_I2C_WDATA(I_DATA_RD),
    .I_USR_WE   (I_USR_WE),
    .I_USR_ADDR (I_USR_ADDR),
    .I_USR_WDATA(I_USR_WDATA),
    .I_PTR      (ptr_q),
    .O_PTR_RDATA(ptr_rdata),
    .O_USR_RDATA(O_USR_RDATA),
    .O_USR_COLL (O_USR_COLL)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= ST_IDLE;
      vl_q      <= 1'b0;
      busy_q    <= 1'b0;
      ptr_q     <= '0;
      ack_q     <= NACK;
      data_q    <= '0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      vl_q     <= I_DATA_VL;
      busy_q   <= I_BUSY;
      wr_stb_q <= 1'b0;
      if (busy_fall) begin
        state_q <= ST_IDLE;
        ack_q   <= NACK;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (ev) begin
              if (I_ADDR_SLV == ADDR_SLV) begin
                ack_q <= ACK;
                if (I_RW) begin
                  state_q <= ST_RDATA;
                  data_q  <= ptr_rdata;
                end else begin
                  state_q <= ST_PTR;
                end
              end else begin
                ack_q   <= NACK;
                state_q <= ST_SKIP;
              end
            end
          end
          ST_PTR: begin
            if (ev) begin
              if (ptr_ok) begin
                ptr_q   <= I_DATA_RD[PTR_W-1:0];
                ack_q   <= ACK;
                state_q <= ST_WDATA;
              end else begin
                ack_q   <= NACK;
                state_q <= ST_SKIP;
              end
            end
          end
          ST_WDATA: begin
            if (ev) begin
              wr_stb_q  <= 1'b1;
              wr_addr_q <= ptr_q;
              ptr_q     <= ptr_q + PTR_W'(1);
              ack_q     <= ACK;
            end
          end
          ST_RDATA: begin
            // Track regs[ptr] every cycle so user writes show up on the byte being served.
            data_q <= ptr_rdata;
            if (I_BYTE_TX && (I_ACK_MSTR == ACK)) ptr_q <= ptr_q + PTR_W'(1);
          end
          ST_SKIP: ack_q <= NACK;
          default: begin
            state_q <= ST_IDLE;
            ack_q   <= NACK;
          end
        endcase
      end
    end
  end

  assign O_ACK     = ack_q;
  assign O_DATA_WR = data_q;
  assign O_REG_PTR = ptr_q;
  assign O_WR_STB  = wr_stb_q;
  assign O_WR_ADDR = wr_addr_q;
  assign O_STATE   = state_q;

endmodule

// File: tb/tb_slv_i2c_reg_ctrl.sv
// Randomised transaction-level bench for slv_i2c_reg_ctrl with a write-strobe/collision scoreboard.
module tb_slv_i2c_reg_ctrl;
  import slv_i2c_pkg::*;

  localparam int DATA_SZ = 8;
  localparam int REG_NUM = 16;
  localparam int PTR_W   = 4;

  logic               CLK = 1'b0;
  logic               RST_n = 1'b0;
  logic [6:0]         I_ADDR_SLV = '0;
  logic               I_RW = 1'b0;
  logic [7:0]         I_DATA_RD = '0;
  logic               I_DATA_VL = 1'b0;
  logic               I_BUSY = 1'b0;
  logic               I_BYTE_TX = 1'b0;
  logic               I_ACK_MSTR = 1'b0;
  logic               O_ACK;
  logic [7:0]         O_DATA_WR;
  logic [PTR_W-1:0]   O_REG_PTR;
  logic               O_WR_STB;
  logic [PTR_W-1:0]   O_WR_ADDR;
  logic [PTR_W-1:0]   I_USR_ADDR = '0;
  logic [7:0]         O_USR_RDATA;
  logic               I_USR_WE = 1'b0;
  logic [7:0]         I_USR_WDATA = '0;
  logic               O_USR_COLL;
  logic [4:0]         O_STATE;

  slv_i2c_reg_ctrl #(.DATA_SZ(DATA_SZ), .ADDR_SLV(7'h3C), .REG_NUM(REG_NUM)) dut (
    .CLK(CLK), .RST_n(RST_n), .I_ADDR_SLV(I_ADDR_SLV), .I_RW(I_RW),
    .I_DATA_RD(I_DATA_RD), .I_DATA_VL(I_DATA_VL), .I_BUSY(I_BUSY),
    .I_BYTE_TX(I_BYTE_TX), .I_ACK_MSTR(I_ACK_MSTR), .O_ACK(O_ACK),
    .O_DATA_WR(O_DATA_WR), .O_REG_PTR(O_REG_PTR), .O_WR_STB(O_WR_STB),
    .O_WR_ADDR(O_WR_ADDR), .I_USR_ADDR(I_USR_ADDR), .O_USR_RDATA(O_USR_RDATA),
    .I_USR_WE(I_USR_WE), .I_USR_WDATA(I_USR_WDATA), .O_USR_COLL(O_USR_COLL),
    .O_STATE(O_STATE)
  );

  // ---------------- clock / reset ----------------
  always #10 CLK = ~CLK;

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model & scoreboard ----------------
  int               n_vec = 0;
  int               n_err = 0;
  logic [7:0]       m_regs [REG_NUM];
  logic [PTR_W-1:0] m_ptr;
  logic [PTR_W-1:0] exp_q[$];
  logic             coll_q[$];
  logic [7:0]       tx_b [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT emits a write strobe or collision pulse.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST_n) begin
        if (O_WR_STB) begin
          if (exp_q.size() == 0) chk("wr_stb_unexpected", 32'd1, 32'd0);
          else chk("wr_addr", O_WR_ADDR, exp_q.pop_front());
        end
        if (O_USR_COLL) begin
          if (coll_q.size() == 0) chk("coll_unexpected", 32'd1, 32'd0);
          else chk("coll", O_USR_COLL, coll_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic start_txn();
    I_BUSY = 1'b1;
    tick(2);
  endtask

  task automatic stop_txn();
    I_BUSY = 1'b0;
    tick(2);
    chk("idle_state", O_STATE, ST_IDLE);
    chk("idle_ack", O_ACK, NACK);
    chk("ptr_after_stop", O_REG_PTR, m_ptr);
  endtask

  task automatic put_byte(input logic [6:0] a, input logic rw, input logic [7:0] d,
                          input logic uwe, input logic [3:0] ua, input logic [7:0] ud,
                          input logic exp_ack);
    I_ADDR_SLV = a; I_RW = rw; I_DATA_RD = d; I_DATA_VL = 1'b1;
    I_USR_WE = uwe; I_USR_ADDR = ua; I_USR_WDATA = ud;
    tick(1);
    I_USR_WE = 1'b0;
    tick(2);
    chk("ack", O_ACK, exp_ack);
    I_DATA_VL = 1'b0;
    tick(2);
  endtask

  task automatic usr_write(input logic [3:0] ua, input logic [7:0] ud);
    I_USR_WE = 1'b1; I_USR_ADDR = ua; I_USR_WDATA = ud;
    tick(1);
    I_USR_WE = 1'b0;
    m_regs[ua] = ud;
    tick(1);
  endtask

  task automatic sweep_regs();
    for (int i = 0; i < REG_NUM; i++) begin
      I_USR_ADDR = PTR_W'(i);
      #1;
      chk("usr_rdata", O_USR_RDATA, m_regs[i]);
    end
  endtask

  // Write transaction: command, pointer byte, data bytes in tx_b[0..nb-1]; optional user
  // write issued together with byte coll_idx.
  task automatic wr_txn(input logic [6:0] addr, input int nb, input int coll_idx,
                        input logic [3:0] ua, input logic [7:0] ud);
    bit ok;
    bit writing;
    logic ea;
    ok = (addr == 7'h3C);
    writing = 1'b0;
    start_txn();
    put_byte(addr, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, ok ? ACK : NACK);
    if (!ok) chk("skip_state", O_STATE, ST_SKIP);
    for (int i = 0; i < nb; i++) begin
      bit uwe = (i == coll_idx);
      if (ok && writing) begin
        exp_q.push_back(m_ptr);
        m_regs[m_ptr] = tx_b[i];
        m_ptr = m_ptr + 1'b1;
        if (uwe) coll_q.push_back(1'b1);
        ea = ACK;
      end else begin
        if (ok && tx_b[i] < 8'd16) begin
          m_ptr = tx_b[i][3:0];
          writing = 1'b1;
          ea = ACK;
        end else begin
          ok = 1'b0;
          ea = NACK;
        end
        if (uwe) m_regs[ua] = ud;
      end
      put_byte(7'h00, 1'b0, tx_b[i], uwe, ua, ud, ea);
      if (!ok) chk("skip_state", O_STATE, ST_SKIP);
    end
    stop_txn();
  endtask

  // Read transaction: nb bytes served, master ack bit i from macks[i], user write to the
  // current pointer before byte i when uwr[i] is set.
  task automatic rd_txn(input logic [6:0] addr, input int nb, input logic [7:0] macks,
                        input logic [7:0] uwr);
    bit ok;
    ok = (addr == 7'h3C);
    start_txn();
    put_byte(addr, 1'b1, 8'h00, 1'b0, 4'h0, 8'h00, ok ? ACK : NACK);
    for (int i = 0; i < nb; i++) begin
      if (uwr[i]) begin
        usr_write(m_ptr, 8'($urandom));
        tick(1);
      end
      if (ok) chk("rd_data", O_DATA_WR, m_regs[m_ptr]);
      I_BYTE_TX = 1'b1; I_ACK_MSTR = macks[i];
      tick(1);
      I_BYTE_TX = 1'b0;
      if (ok && macks[i] == ACK) m_ptr = m_ptr + 1'b1;
      tick(3);
    end
    if (ok) chk("rd_data_last", O_DATA_WR, m_regs[m_ptr]);
    chk("rd_ptr", O_REG_PTR, m_ptr);
    stop_txn();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < REG_NUM; i++) m_regs[i] = '0;
    m_ptr = '0;
    tick(3);
    chk("rst_ack", O_ACK, 1'b1);
    chk("rst_data", O_DATA_WR, 8'h00);
    chk("rst_ptr", O_REG_PTR, 4'h0);
    chk("rst_stb", O_WR_STB, 1'b0);
    chk("rst_coll", O_USR_COLL, 1'b0);
    chk("rst_state", O_STATE, ST_IDLE);
    RST_n = 1'b1;
    tick(2);
    sweep_regs();

    // Write 0xA1, 0xB2 at pointer 5.
    tx_b[0] = 8'h05; tx_b[1] = 8'hA1; tx_b[2] = 8'hB2;
    wr_txn(7'h3C, 3, -1, 4'h0, 8'h00);
    chk("ptr_is_7", O_REG_PTR, 4'd7);
    // Current-address read: ACK, ACK, NACK.
    rd_txn(7'h3C, 3, 8'b100, 8'h00);
    chk("ptr_is_9", O_REG_PTR, 4'd9);
    // Foreign address.
    tx_b[0] = 8'h01; tx_b[1] = 8'hFF;
    wr_txn(7'h2A, 2, -1, 4'h0, 8'h00);
    // Pointer wrap, then out-of-range pointer.
    tx_b[0] = 8'h0F; tx_b[1] = 8'h11; tx_b[2] = 8'h22;
    wr_txn(7'h3C, 3, -1, 4'h0, 8'h00);
    tx_b[0] = 8'h10; tx_b[1] = 8'h33;
    wr_txn(7'h3C, 2, -1, 4'h0, 8'h00);
    // Collision on regs[3], then a clean user write.
    tx_b[0] = 8'h03; tx_b[1] = 8'h55;
    wr_txn(7'h3C, 2, 1, 4'h3, 8'h99);
    usr_write(4'h4, 8'h77);
    sweep_regs();
    // Data byte arriving together with I_BUSY falling must not write.
    start_txn();
    put_byte(7'h3C, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, ACK);
    put_byte(7'h00, 1'b0, 8'h01, 1'b0, 4'h0, 8'h00, ACK);
    m_ptr = 4'h1;
    I_DATA_RD = 8'hEE; I_DATA_VL = 1'b1; I_BUSY = 1'b0;
    tick(3);
    I_DATA_VL = 1'b0;
    tick(2);
    chk("busyfall_state", O_STATE, ST_IDLE);
    chk("busyfall_ptr", O_REG_PTR, m_ptr);
    sweep_regs();

    // Randomised transactions.
    for (int t = 0; t < 40; t++) begin
      logic [6:0] a;
      a = ($urandom_range(0, 4) == 0) ? 7'($urandom) : 7'h3C;
      if ($urandom_range(0, 1) == 0) begin
        int nb;
        nb = $urandom_range(0, 5);
        tx_b[0] = 8'($urandom_range(0, 20));
        for (int k = 1; k < 8; k++) tx_b[k] = 8'($urandom);
        wr_txn(a, nb, ($urandom_range(0, 2) == 0) ? $urandom_range(0, 5) : -1,
               4'($urandom), 8'($urandom));
      end else begin
        rd_txn(a, $urandom_range(1, 4), 8'($urandom), ($urandom_range(0, 3) == 0) ? 8'h02 : 8'h00);
      end
      if ($urandom_range(0, 3) == 0) usr_write(4'($urandom), 8'($urandom));
    end
    sweep_regs();

    // Reset in the middle of a write transaction.
    start_txn();
    put_byte(7'h3C, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, ACK);
    put_byte(7'h00, 1'b0, 8'h02, 1'b0, 4'h0, 8'h00, ACK);
    m_ptr = 4'h2;
    exp_q.push_back(m_ptr);
    m_regs[m_ptr] = 8'h5A;
    m_ptr = m_ptr + 1'b1;
    put_byte(7'h00, 1'b0, 8'h5A, 1'b0, 4'h0, 8'h00, ACK);
    chk("pre_rst_state", O_STATE, ST_WDATA);
    RST_n = 1'b0;
    #1;
    chk("mid_rst_ack", O_ACK, 1'b1);
    chk("mid_rst_data", O_DATA_WR, 8'h00);
    chk("mid_rst_ptr", O_REG_PTR, 4'h0);
    chk("mid_rst_wr_addr", O_WR_ADDR, 4'h0);
    chk("mid_rst_state", O_STATE, ST_IDLE);
    I_BUSY = 1'b0;
    tick(2);
    RST_n = 1'b1;
    for (int i = 0; i < REG_NUM; i++) m_regs[i] = '0;
    m_ptr = '0;
    tick(2);
    sweep_regs();
    chk("post_rst_ptr", O_REG_PTR, 4'h0);

    tick(4);
    chk("wr_q_drained", exp_q.size(), 0);
    chk("coll_q_drained", coll_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/slv_i2c_reg_ctrl.md
# slv_i2c_reg_ctrl

Register-bank controller behind `slv_i2c_fsm`. It decodes each latched command and data byte from the slave FSM, decides ACK/NACK, and maintains an auto-incrementing register pointer. It owns a REG_NUM x DATA_SZ register file, serves bytes for master reads, and exposes a user-side port so local logic can read and write the same registers.

## Interface
- DATA_SZ, 8, byte width; must equal the slave FSM DATA_SZ
- ADDR_SLV, 7'h3C, own I2C address (DATA_SZ-1 bits)
- REG_NUM, 16, register count; power of two, 2..2^DATA_SZ; PTR_W = $clog2(REG_NUM)
- CLK  in  1  clock, 50 MHz
- RST_n  in  1  reset RST_n, asynchronous, active-low; clock CLK
- I_ADDR_SLV  in  DATA_SZ-1  address latched by slave FSM
- I_RW  in  1  R/W bit latched by slave FSM (1 = master reads)
- I_DATA_RD  in  DATA_SZ  byte received from master
- I_DATA_VL  in  1  level from slave FSM; high while a command/byte is latched; only its rising edge is used
- I_BUSY  in  1  transaction active (START seen, not yet STOP)
- I_BYTE_TX  in  1  one-CLK strobe from slave top each time the master ACK bit of a transmitted byte is sampled
- I_ACK_MSTR  in  1  master ACK bit, valid with I_BYTE_TX (0 = ACK)
- O_ACK  out  1  to slave FSM I_ACK; 0 = ACK, 1 = NACK
- O_DATA_WR  out  DATA_SZ  byte to slave FSM I_DATA_WR (registered)
- O_REG_PTR  out  PTR_W  current register pointer
- O_WR_STB  out  1  one-CLK pulse when the I2C side writes a register
- O_WR_ADDR  out  PTR_W  register index written, valid with O_WR_STB
- I_USR_ADDR  in  PTR_W  user read/write index
- O_USR_RDATA  out  DATA_SZ  regs[I_USR_ADDR], combinational
- I_USR_WE  in  1  user write enable
- I_USR_WDATA  in  DATA_SZ  user write data
- O_USR_COLL  out  1  one-CLK pulse when a user write is dropped due to collision

## Operation
- Byte event `ev` = rising edge of I_DATA_VL (registered previous value); all decoding happens on `ev` only.
- States: IDLE, PTR, WDATA, RDATA, SKIP.
- IDLE, `ev` (first byte of a transaction = command):
  - I_ADDR_SLV == ADDR_SLV and I_RW = 0: O_ACK = 0, go to PTR.
  - I_ADDR_SLV == ADDR_SLV and I_RW = 1: O_ACK = 0, O_DATA_WR = regs[ptr], go to RDATA.
  - Address mismatch: O_ACK = 1, go to SKIP.
- PTR, `ev`:
  - I_DATA_RD < REG_NUM: ptr = I_DATA_RD[PTR_W-1:0], O_ACK = 0, go to WDATA.
  - Otherwise: O_ACK = 1, go to SKIP.
- WDATA, `ev`: regs[ptr] = I_DATA_RD, O_WR_STB = 1 with O_WR_ADDR = ptr, ptr = ptr + 1 mod REG_NUM, O_ACK = 0.
- RDATA, I_BYTE_TX:
  - I_ACK_MSTR = 0: ptr = ptr + 1 mod REG_NUM, then O_DATA_WR = regs[new ptr].
  - I_ACK_MSTR = 1: hold ptr and O_DATA_WR.
- SKIP: ignore `ev` and I_BYTE_TX; O_ACK stays 1.
- Any state, I_BUSY falling: go to IDLE and set O_ACK = 1. Ptr is retained, so a later read without a pointer byte continues from ptr (current-address read).
- Write priority: an I2C write and I_USR_WE in the same cycle means the I2C write wins, the user write is dropped and O_USR_COLL pulses. A user write with no I2C write in that cycle updates regs[I_USR_ADDR].
- A user write to regs[ptr] while in RDATA is reflected in O_DATA_WR on the next CLK.

## Timing
- Reset values: state IDLE, ptr 0, all regs 0, O_ACK 1, O_DATA_WR 0, O_WR_STB 0, O_WR_ADDR 0, O_USR_COLL 0. O_USR_RDATA follows regs, so it reads 0.
- O_ACK settles at most 2 CLK after the I_DATA_VL rising edge. The slave FSM samples O_ACK at mid-SCL-low, many CLKs later.
- O_DATA_WR valid 2 CLK after entering RDATA and 2 CLK after I_BYTE_TX. The slave FSM loads it at the next mid-SCL-low.
- O_WR_STB is asserted in the cycle after `ev`; the register content is updated in that same cycle.
- Pointer wrap: REG_NUM-1 + 1 gives 0, for both writes and reads.
- `ev` and I_BUSY falling in the same cycle: I_BUSY falling wins; no write occurs.
- Reset mid-transaction returns everything to the reset values above. regs are cleared.

## Structure
- Package `slv_i2c_pkg`:
  - state encoding (one-hot, 5 bits);
  - ACK = 1'b0, NACK = 1'b1;
  - default ADDR_SLV.
- Sub-module `slv_i2c_regfile`:
  - REG_NUM x DATA_SZ array;
  - one write port with the I2C/user priority mux and collision flag;
  - two read ports: regs[ptr] and regs[I_USR_ADDR].
- The FSM, edge detect and pointer logic live in `slv_i2c_reg_ctrl`.

## Test plan
- Command 0x3C/W, pointer 0x05, data 0xA1, 0xB2, STOP -> O_ACK 0 for every byte; regs[5] = 0xA1, regs[6] = 0xB2; two O_WR_STB pulses with O_WR_ADDR 5 then 6; final ptr 7.
- Command 0x3C/R after the above, master ACK, ACK, NACK -> O_DATA_WR = 0x00 (regs[7]), then regs[8], then regs[9]; ptr ends at 9 and is held after the NACK.
- Command 0x2A/W -> O_ACK 1 and state SKIP; following bytes 0x01, 0xFF -> no O_WR_STB; I_BUSY falling returns to IDLE.
- Pointer 0x0F, data 0x11, 0x22 -> regs[15] = 0x11, regs[0] = 0x22 (wrap); pointer 0x10 -> NACK, state SKIP, regs unchanged.
- I2C write to regs[3] = 0x55 in the same cycle as a user write of regs[3] = 0x99 -> regs[3] = 0x55, one O_USR_COLL pulse; a user write of 0x77 to regs[4] in another cycle -> O_USR_RDATA at index 4 = 0x77.
- RST_n low in WDATA after one byte -> all outputs at reset values, regs 0, state IDLE.
